// File: rtl/sort_pkg.sv
// Shared sizing for the radix-sort datapath.
package sort_pkg;
    localparam int M = 8;
endpackage

// File: rtl/sort_sched_if.sv
// Load/stream bundle of the sort scheduler; master = load source and consumer, slave = scheduler.
interface sort_sched_if #(
    parameter int M = sort_pkg::M,
    parameter int W = 8
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic            i_load;
    logic [M*W-1:0]  i_data;
    logic            o_busy;
    logic            o_valid;
    logic            i_ready;
    logic [IW-1:0]   o_idx;
    logic [W-1:0]    o_data;
    logic            o_done;

    modport master (
        output i_load, i_data, i_ready,
        input  o_busy, o_valid, o_idx, o_data, o_done
    );

    modport slave (
        input  i_load, i_data, i_ready,
        output o_busy, o_valid, o_idx, o_data, o_done
    );
endinterface

// File: rtl/sort_sched.sv
// Bit-serial MSB-first extremum search over M stored words, emitted in stable sorted order.
// W scan cycles plus one emit cycle per word; the winner is held on o_idx/o_data while i_ready is low.
module sort_sched #(
    parameter int M       = sort_pkg::M,
    parameter int W       = 8,
    parameter bit DESCEND = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    sort_sched_if.slave bus
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  mem_q [M];
    logic [M-1:0]  active_q, active_d;
    logic [M-1:0]  cand_q, cand_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  data_q, data_d;

    logic [M-1:0]  plane, hit, narrowed, active_clr;
    logic [IW-1:0] win_idx;
    logic          load_acc;

    // Ascending order inverts each plane so the same "keep the ones" narrowing finds the minimum.
    always_comb begin
        plane = '0;
        for (int k = 0; k < M; k++) begin
            plane[k] = mem_q[k][bit_q] ^ ~DESCEND;
        end
        hit      = cand_q & plane;
        narrowed = (|hit) ? hit : cand_q;
        win_idx  = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (narrowed[k]) win_idx = IW'(k);
        end
        active_clr = active_q;
        for (int k = 0; k < M; k++) begin
            if (idx_q == IW'(k)) active_clr[k] = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        cand_d   = cand_q;
        bit_d    = bit_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        data_d   = data_q;
        load_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_load) begin
                    load_acc = 1'b1;
                    active_d = '1;
                    cand_d   = '1;
                    bit_d    = BW'(W - 1);
                    rem_d    = CW'(M);
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                cand_d = narrowed;
                if (bit_q == '0) begin
                    idx_d   = win_idx;
                    data_d  = mem_q[win_idx];
                    state_d = EMIT;
                end else begin
                    bit_d = bit_q - BW'(1);
                end
            end
            EMIT: begin
                if (bus.i_ready) begin
                    active_d = active_clr;
                    rem_d    = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = DONE;
                    end else begin
                        cand_d  = active_clr;
                        bit_d   = BW'(W - 1);
                        state_d = SCAN;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            active_q <= '0;
            cand_q   <= '0;
            bit_q    <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            cand_q   <= cand_d;
            bit_q    <= bit_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < M; k++) mem_q[k] <= '0;
        end else if (load_acc) begin
            for (int k = 0; k < M; k++) mem_q[k] <= bus.i_data[k*W +: W];
        end
    end

    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_valid = (state_q == EMIT);
    assign bus.o_done  = (state_q == DONE);
    assign bus.o_idx   = idx_q;
    assign bus.o_data  = data_q;
endmodule

// File: tb/tb_sort_sched.sv
// Directed bench: a descending and an ascending instance (M=4, W=4) driven in lockstep.
module tb_sort_sched;
    localparam int M = 4;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ready;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sort_sched_if #(.M(M), .W(W)) bus_d ();
    sort_sched_if #(.M(M), .W(W)) bus_a ();

    sort_sched #(.M(M), .W(W), .DESCEND(1'b1)) u_desc (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_d));
    sort_sched #(.M(M), .W(W), .DESCEND(1'b0)) u_asc  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [15:0] d);
        bus_d.i_load = ld;
        bus_a.i_load = ld;
        bus_d.i_data = d;
        bus_a.i_data = d;
    endtask

    // Expected emission k sits at idx[2k+:2], data[4k+:4].
    task automatic run_sort(input string name, input logic [15:0] d,
                            input logic [7:0] di, input logic [15:0] dd,
                            input logic [7:0] ai, input logic [15:0] ad,
                            input int stall, input int bl_cyc, input logic [15:0] bl_data,
                            input int exp_last);
        int kd = 0, ka = 0, fv = -1, last = -1, sc = stall;
        logic [7:0]  eidx;
        logic [15:0] edat;
        ready = 1'b1;
        bus_d.i_ready = 1'b1;
        bus_a.i_ready = 1'b1;
        drive(1'b1, d);
        tick();
        bus_d.i_load = 1'b0;
        bus_a.i_load = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            bus_d.i_load = 1'b0;
            bus_a.i_load = 1'b0;
            if (cyc == bl_cyc) drive(1'b1, bl_data);
            if (cyc == 1) check({name, " busy"}, 32'(bus_d.o_busy), 32'd1);
            if (bus_d.o_valid && fv < 0) fv = cyc;
            if (bus_d.o_valid && kd == 0 && sc > 0) begin
                ready = 1'b0;
                sc--;
                eidx = di; edat = dd;
                check({name, " stall d idx"}, 32'(bus_d.o_idx), 32'(eidx[1:0]));
                check({name, " stall d data"}, 32'(bus_d.o_data), 32'(edat[3:0]));
                eidx = ai; edat = ad;
                check({name, " stall a valid"}, 32'(bus_a.o_valid), 32'd1);
                check({name, " stall a idx"}, 32'(bus_a.o_idx), 32'(eidx[1:0]));
                check({name, " stall a data"}, 32'(bus_a.o_data), 32'(edat[3:0]));
            end else begin
                ready = 1'b1;
            end
            bus_d.i_ready = ready;
            bus_a.i_ready = ready;
            if (bus_d.o_valid && ready && kd < 4) begin
                eidx = di >> (2 * kd); edat = dd >> (4 * kd);
                check($sformatf("%s d idx%0d", name, kd), 32'(bus_d.o_idx), 32'(eidx[1:0]));
                check($sformatf("%s d data%0d", name, kd), 32'(bus_d.o_data), 32'(edat[3:0]));
                kd++;
            end
            if (bus_a.o_valid && ready && ka < 4) begin
                eidx = ai >> (2 * ka); edat = ad >> (4 * ka);
                check($sformatf("%s a idx%0d", name, ka), 32'(bus_a.o_idx), 32'(eidx[1:0]));
                check($sformatf("%s a data%0d", name, ka), 32'(bus_a.o_data), 32'(edat[3:0]));
                ka++;
            end
            if (kd == 4 && ka == 4) begin
                last = cyc + 1;
                break;
            end
        end
        tick();
        check({name, " d count"}, 32'(kd), 32'd4);
        check({name, " a count"}, 32'(ka), 32'd4);
        check({name, " first valid"}, 32'(fv), 32'd4);
        check({name, " last hs"}, 32'(last), 32'(exp_last));
        check({name, " d done"}, 32'(bus_d.o_done), 32'd1);
        check({name, " a done"}, 32'(bus_a.o_done), 32'd1);
        tick();
        check({name, " d done drop"}, 32'(bus_d.o_done), 32'd0);
        check({name, " d idle"}, 32'(bus_d.o_busy), 32'd0);
        check({name, " a idle"}, 32'(bus_a.o_busy), 32'd0);
    endtask

    initial begin
        ready = 1'b1;
        bus_d.i_ready = 1'b1;
        bus_a.i_ready = 1'b1;
        drive(1'b0, 16'h0000);
        #1 rst_n = 1'b0;
        #20;
        check("rst busy",  32'(bus_d.o_busy),  32'd0);
        check("rst valid", 32'(bus_d.o_valid), 32'd0);
        check("rst done",  32'(bus_d.o_done),  32'd0);
        check("rst idx",   32'(bus_d.o_idx),   32'd0);
        check("rst data",  32'(bus_d.o_data),  32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // data {3,9,9,0}
        run_sort("basic", 16'h0993, {2'd3, 2'd0, 2'd2, 2'd1}, 16'h0399,
                 {2'd2, 2'd1, 2'd0, 2'd3}, 16'h9930, 0, -1, 16'h0, 20);
        run_sort("stall", 16'h0993, {2'd3, 2'd0, 2'd2, 2'd1}, 16'h0399,
                 {2'd2, 2'd1, 2'd0, 2'd3}, 16'h9930, 5, -1, 16'h0, 25);
        run_sort("busyld", 16'h0993, {2'd3, 2'd0, 2'd2, 2'd1}, 16'h0399,
                 {2'd2, 2'd1, 2'd0, 2'd3}, 16'h9930, 0, 2, 16'h1234, 20);
        // data {4,3,2,1}
        run_sort("newld", 16'h1234, {2'd3, 2'd2, 2'd1, 2'd0}, 16'h1234,
                 {2'd0, 2'd1, 2'd2, 2'd3}, 16'h4321, 0, -1, 16'h0, 20);

        drive(1'b1, 16'h0993);
        tick();
        drive(1'b0, 16'h0993);
        for (int i = 0; i < 6; i++) tick();
        check("pre-rst busy", 32'(bus_d.o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst d busy",  32'(bus_d.o_busy),  32'd0);
        check("async rst d valid", 32'(bus_d.o_valid), 32'd0);
        check("async rst d done",  32'(bus_d.o_done),  32'd0);
        check("async rst a busy",  32'(bus_a.o_busy),  32'd0);
        check("async rst d idx",   32'(bus_d.o_idx),   32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("post-rst busy",  32'(bus_d.o_busy),  32'd0);
        check("post-rst valid", 32'(bus_a.o_valid), 32'd0);

        run_sort("all15", 16'hFFFF, {2'd3, 2'd2, 2'd1, 2'd0}, 16'hFFFF,
                 {2'd3, 2'd2, 2'd1, 2'd0}, 16'hFFFF, 0, -1, 16'h0, 20);
        run_sort("all0", 16'h0000, {2'd3, 2'd2, 2'd1, 2'd0}, 16'h0000,
                 {2'd3, 2'd2, 2'd1, 2'd0}, 16'h0000, 0, -1, 16'h0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sort_sched.md
Name: sort_sched

Overview:
- Bit-serial sort scheduler for the radix-sort datapath.
- Holds M words of W bits and repeatedly runs the MSB-first candidate-narrowing search, one bit plane per cycle, to find the current extremum.
- Emits each winner (index and data) over a valid/ready stream, removes it from the active set, and repeats until all M words have been emitted in sorted order.
- Sits between the load source and the downstream consumer of the sorted stream.

Parameters:
- M, 8, number of elements; taken from sort_pkg.
- W, 8, element width in bits.
- DESCEND, 1. 1 = emit largest first; 0 = emit smallest first (each bit plane is inverted before narrowing).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_load  in  1  load request; accepted only in IDLE.
- i_data  in  M*W  element k occupies bits [k*W +: W].
- o_busy  out  1  high in every state except IDLE.
- o_valid  out  1  winner available.
- i_ready  in  1  consumer accepts the winner.
- o_idx  out  $clog2(M)  index of the winner.
- o_data  out  W  value of the winner.
- o_done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low (i_rst_n).
- Reset values: state = IDLE; o_busy, o_valid, o_done = 0; o_idx, o_data = 0; active mask = 0; storage array = 0.
- Reset asserted mid-operation aborts immediately to IDLE with the reset values above; stored data is discarded.
- Narrowing step, per bit plane j:
  - Build the plane x_j[k] = bit j of element k, inverted when DESCEND = 0.
  - h = cand & x_j.
  - cand_next = h if h is nonzero, else cand.
- State IDLE:
  - When i_load = 1: capture i_data into storage, set active = all ones, cand = all ones, bit index = W-1, go to SCAN.
  - When i_load = 0: stay in IDLE.
- State SCAN:
  - Each cycle: cand <= narrowing(cand, plane at bit index); bit index decrements.
  - On the cycle processing bit 0, go to EMIT.
  - SCAN lasts exactly W cycles.
- State EMIT:
  - o_valid = 1. o_idx = lowest set index of cand (ties resolve to the lowest index). o_data = storage[o_idx].
  - o_idx and o_data are registered and stable while i_ready = 0; stalls are unbounded.
  - On a handshake (o_valid & i_ready): clear the winner bit in active and decrement the remaining count.
    - If remaining becomes 0: go to DONE.
    - Otherwise: cand <= new active, bit index = W-1, go to SCAN.
  - o_valid drops in the cycle after the handshake.
- State DONE: o_done = 1 for one cycle, then go to IDLE.
- Timing:
  - First o_valid occurs W cycles after the load edge.
  - With i_ready held at 1, the full sort takes M*(W+1) cycles from load to the last handshake, plus 1 cycle for o_done.
- Load outside IDLE: i_load is ignored while o_busy = 1.
- Load in the o_done cycle: i_load is ignored in DONE and is accepted from IDLE in the next cycle.
- Equal values: emitted in ascending index order, i.e. the sort is stable in both directions.
- Cleared elements never re-enter cand; cand is always a nonzero subset of active in SCAN and EMIT.
- Width rules:
  - Remaining count is $clog2(M+1) bits.
  - Bit index is $clog2(W) bits and does not wrap; its exit is decoded at 0.
  - M = 1 is legal: one SCAN pass and one EMIT.

Test Plan:
- Basic descending sort. Setup: M=4, W=4, DESCEND=1, data {3,9,9,0}, i_ready=1.
  - Required output: emits (idx,data) (1,9), (2,9), (0,3), (3,0).
  - First o_valid 4 cycles after load; o_done at cycle 21.
- Ascending sort. Setup: DESCEND=0, same data.
  - Required output: (3,0), (0,3), (1,9), (2,9).
- Backpressure. Hold i_ready=0 for 5 cycles during the first EMIT.
  - Required: o_valid stays 1; o_idx and o_data stay constant; no element is skipped; total cycles grow by 5.
- Load while busy. Pulse i_load with new data during SCAN.
  - Required: ignored; the original stream completes unchanged.
  - A subsequent load in IDLE sorts the new data.
- Reset mid-operation. Deassert i_rst_n asynchronously during the second SCAN.
  - Required: o_busy, o_valid, o_done fall immediately with no clock edge.
  - After release, the block idles until a new i_load.
- All-equal and extreme values. Setup: data {15,15,15,15}, then {0,0,0,0}.
  - Required: indices emitted in order 0, 1, 2, 3 for both.
  - Each run takes exactly 20 cycles to the last handshake.
